// File: rtl/ms_m_pipe.sv
// Instruction splitter: buffers instruction words in a 2-entry queue and presents
//   the head split into opcode / extended immediate, plus the raw word.
// Latency: a word pushed into an empty queue is presented (out_valid=1) one cycle later.
// Backpressure: in_ready drops when the queue is full or the block is HALTed.
//   in_ready never depends combinationally on out_ready.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   Instruction/in_valid/in_ready      instruction word in, valid/ready handshake
//   Instruction2/opcode/num/out_valid/out_ready   head entry out, valid/ready handshake
//   halted/resume                HALT state flag, single-cycle pulse to leave HALT
module ms_m_pipe #(
  parameter int IW       = 8,
  parameter int OPW      = 2,
  parameter int DW       = 8,
  parameter int SIGN_EXT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  Instruction,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [IW-1:0]  Instruction2,
  output logic [OPW-1:0] opcode,
  output logic [DW-1:0]  num,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           halted,
  input  logic           resume
);

  localparam int IMW = IW - OPW;

  typedef struct packed {
    logic [IW-1:0]  raw;
    logic [OPW-1:0] op;
    logic [DW-1:0]  num;
  } entry_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // Field split and immediate extension happen once, at push time, so the
  // output side is a plain register copy of the head entry.
  function automatic entry_t split_word(input logic [IW-1:0] w);
    entry_t         e;
    logic [IMW-1:0] imm;
    imm   = w[IMW-1:0];
    e.raw = w;
    e.op  = w[IW-1 -: OPW];
    if (SIGN_EXT != 0) begin
      e.num = DW'($signed(imm));
    end else begin
      e.num = DW'(imm);
    end
    return e;
  endfunction

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  state_t     state_q, state_d;

  entry_t     new_e;
  logic       push;
  logic       pop;

  // Gated by rst so the handshake reads idle for the whole reset period.
  assign in_ready  = !rst && (count_q < 2'd2) && (state_q == S_RUN);
  assign out_valid = !rst && (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign Instruction2 = head_q.raw;
  assign opcode       = head_q.op;
  assign num          = head_q.num;
  assign halted       = (state_q == S_HALT);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    new_e   = split_word(Instruction);

    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_e;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_e;
        end else if (push) begin
          tail_d  = new_e;
          count_d = 2'd2;
        end else if (pop) begin
          // Head fields keep their last value while the queue is empty.
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // No push is possible here: in_ready is low whenever the queue is full.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        // The all-ones word is the HALT opcode; it is still queued normally.
        if (push && (&Instruction)) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      state_q <= S_RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule
